// File: rtl/dram_arbiter.sv
// Three-way arbiter (table walker, data port, fetch) onto the single-port dram, one access in flight.
// Define DRAM_ARB_RR_EN to round-robin d/if below tw; default build is fixed priority tw > d > if.
module dram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tw_valid,
  output logic              tw_ready,
  input  logic [ADDR_W-1:0] tw_addr,
  output logic              tw_rsp_valid,
  output logic [DATA_W-1:0] tw_rsp_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_TW, OWN_D, OWN_IF} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, grant;
  logic              grant_any;
  logic              accept;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [1:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_bad;
  logic [DATA_W-1:0] tw_data_q, d_data_q, if_data_q;
  logic              d_err_q;

`ifdef DRAM_ARB_RR_EN
  logic rr_if_turn;
`endif

  assign cmd_bad = (cmd_size == 2'b11);
  // readies are gated by reset so every output is 0 while reset is held
  assign accept  = reset_n && (state == S_IDLE) && grant_any;

  always_comb begin
    grant_any = 1'b0;
    grant     = OWN_D;
    if (tw_valid) begin
      grant_any = 1'b1;
      grant     = OWN_TW;
`ifdef DRAM_ARB_RR_EN
    end else if (d_valid && (!rr_if_turn || !if_valid)) begin
`else
    end else if (d_valid) begin
`endif
      grant_any = 1'b1;
      grant     = OWN_D;
    end else if (if_valid) begin
      grant_any = 1'b1;
      grant     = OWN_IF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= OWN_D;
      cmd_addr  <= '0;
      cmd_we    <= 1'b0;
      cmd_size  <= '0;
      cmd_wdata <= '0;
      tw_data_q <= '0;
      d_data_q  <= '0;
      if_data_q <= '0;
      d_err_q   <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      rr_if_turn <= 1'b0;
`endif
    end else begin
      if (accept) begin
        owner    <= grant;
        cmd_we   <= (grant == OWN_D) && d_we;
        cmd_size <= (grant == OWN_D) ? d_size : 2'b10;
        case (grant)
          OWN_TW:  cmd_addr <= tw_addr;
          OWN_IF:  cmd_addr <= if_addr;
          default: cmd_addr <= d_addr;
        endcase
        if (grant == OWN_D) cmd_wdata <= d_wdata;
`ifdef DRAM_ARB_RR_EN
        if (grant != OWN_TW) rr_if_turn <= (grant == OWN_D);
`endif
      end
      if (state == S_CAPT) begin
        case (owner)
          OWN_TW:  tw_data_q <= mem_rdata;
          OWN_IF:  if_data_q <= mem_rdata;
          default: begin
            d_data_q <= (cmd_we || cmd_bad) ? '0 : mem_rdata;
            d_err_q  <= cmd_bad;
          end
        endcase
      end
    end
  end

  always_comb begin
    tw_ready     = accept && (grant == OWN_TW);
    d_ready      = accept && (grant == OWN_D);
    if_ready     = accept && (grant == OWN_IF);
    mem_ren      = (state == S_ISSUE) && !cmd_we && !cmd_bad;
    mem_wen      = (state == S_ISSUE) &&  cmd_we && !cmd_bad;
    mem_addr     = cmd_addr;
    mem_wdata    = cmd_wdata;
    mem_size     = cmd_size;
    tw_rsp_valid = (state == S_RESP) && (owner == OWN_TW);
    d_rsp_valid  = (state == S_RESP) && (owner == OWN_D);
    if_rsp_valid = (state == S_RESP) && (owner == OWN_IF);
    d_rsp_err    = d_rsp_valid && d_err_q;
    tw_rsp_data  = tw_data_q;
    d_rsp_data   = d_data_q;
    if_rsp_data  = if_data_q;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-timeline reference model plus directed and random stimulus.
// Honours DRAM_ARB_RR_EN the same way as the design.
module tb_dram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        tw_valid, tw_ready, tw_rsp_valid;
  logic [13:0] tw_addr;
  logic [31:0] tw_rsp_data;
  logic        d_valid, d_ready, d_we, d_rsp_valid, d_rsp_err;
  logic [13:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata, d_rsp_data;
  logic        if_valid, if_ready, if_rsp_valid;
  logic [13:0] if_addr;
  logic [31:0] if_rsp_data;
  logic        mem_ren, mem_wen;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  int checks = 0;
  int failures = 0;

  dram_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_addr(tw_addr),
    .tw_rsp_valid(tw_rsp_valid), .tw_rsp_data(tw_rsp_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we),
    .d_size(d_size), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- dram environment: registered read, little-endian lanes
  logic [7:0] dmem [0:16383];
  bit         dmem_init = 1'b0;

  function automatic logic [31:0] dram_load(input logic [13:0] a, input logic [1:0] sz);
    logic [13:0] b;
    case (sz)
      2'b00:   return {24'd0, dmem[a]};
      2'b01: begin b = {a[13:1], 1'b0}; return {16'd0, dmem[b+1], dmem[b]}; end
      default: begin b = {a[13:2], 2'b00}; return {dmem[b+3], dmem[b+2], dmem[b+1], dmem[b]}; end
    endcase
  endfunction

  always @(posedge clock) begin
    logic [13:0] b;
    if (!dmem_init) begin
      for (int i = 0; i < 16384; i++) dmem[i] = 8'((i * 37 + 11) & 255);
      dmem_init = 1'b1;
    end
    if (mem_wen) begin
      case (mem_size)
        2'b00: dmem[mem_addr] = mem_wdata[7:0];
        2'b01: begin
          b = {mem_addr[13:1], 1'b0};
          dmem[b] = mem_wdata[7:0]; dmem[b+1] = mem_wdata[15:8];
        end
        default: begin
          b = {mem_addr[13:2], 2'b00};
          dmem[b] = mem_wdata[7:0];    dmem[b+1] = mem_wdata[15:8];
          dmem[b+2] = mem_wdata[23:16]; dmem[b+3] = mem_wdata[31:24];
        end
      endcase
    end
    if (mem_ren) mem_rdata <= dram_load(mem_addr, mem_size);
  end

  // ---------------- reference model: one access per 4-cycle slot, events on a cycle timeline
  logic [7:0]  refmem [0:16383];
  bit          ref_init = 1'b0;
  int          cyc = 0, op_cyc = -1, rsp_cyc = -1, free_at = 0;
  int          p_own;
  bit          p_we, p_err;
  logic [1:0]  p_size;
  logic [13:0] p_addr;
  logic [31:0] p_wdata, p_rdata;
  logic [31:0] last_rsp [3];
  bit          m_if_turn;
  bit          e_tw, e_d, e_if, e_ren, e_wen, e_rsp;

  function automatic logic [31:0] ref_load(input logic [13:0] a, input logic [1:0] sz);
    int unsigned base;
    if (sz == 2'b00) return {24'd0, refmem[a]};
    if (sz == 2'b01) begin
      base = int'(a) & ~1;
      return {16'd0, refmem[base+1], refmem[base]};
    end
    base = int'(a) & ~3;
    return {refmem[base+3], refmem[base+2], refmem[base+1], refmem[base]};
  endfunction

  task automatic ref_store(input logic [13:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned base;
    int unsigned n;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a) & ~(n - 1);
    for (int unsigned k = 0; k < n; k++) refmem[base + k] = wd[8*k +: 8];
  endtask

  task automatic model_reset();
    op_cyc = -1; rsp_cyc = -1; free_at = 0; m_if_turn = 1'b0;
    for (int i = 0; i < 3; i++) last_rsp[i] = '0;
  endtask

  always @(negedge clock) begin
    if (!ref_init) begin
      for (int i = 0; i < 16384; i++) refmem[i] = 8'((i * 37 + 11) & 255);
      model_reset();
      ref_init = 1'b1;
    end
    if (!reset_n) begin
      check("reset_ctrl", {tw_ready, d_ready, if_ready, tw_rsp_valid, d_rsp_valid,
                           if_rsp_valid, d_rsp_err, mem_ren, mem_wen}, 64'd0);
      check("reset_mem", {mem_addr, mem_size, mem_wdata}, 64'd0);
      check("reset_data", {tw_rsp_data | d_rsp_data | if_rsp_data}, 64'd0);
      model_reset();
    end else begin
      e_tw = 0; e_d = 0; e_if = 0;
      if (cyc >= free_at) begin
        if (tw_valid) e_tw = 1;
`ifdef DRAM_ARB_RR_EN
        else if (d_valid && (!m_if_turn || !if_valid)) e_d = 1;
`else
        else if (d_valid) e_d = 1;
`endif
        else if (if_valid) e_if = 1;
      end
      check("ready", {tw_ready, d_ready, if_ready}, {e_tw, e_d, e_if});

      e_ren = (cyc == op_cyc) && !p_we && p_size != 2'b11;
      e_wen = (cyc == op_cyc) &&  p_we && p_size != 2'b11;
      check("mem_en", {mem_ren, mem_wen}, {e_ren, e_wen});
      if (e_ren || e_wen) check("mem_cmd", {mem_addr, mem_size}, {p_addr, p_size});
      if (e_wen) check("mem_wdata", mem_wdata, p_wdata);
      if (cyc == op_cyc) begin
        p_rdata = e_ren ? ref_load(p_addr, p_size) : '0;
        if (e_wen) ref_store(p_addr, p_size, p_wdata);
      end

      e_rsp = (cyc == rsp_cyc);
      if (e_rsp) last_rsp[p_own] = p_rdata;
      check("rsp_valid", {tw_rsp_valid, d_rsp_valid, if_rsp_valid},
            {e_rsp && p_own == 0, e_rsp && p_own == 1, e_rsp && p_own == 2});
      check("rsp_err", d_rsp_err, e_rsp && p_own == 1 && p_err);
      check("tw_rsp_data", tw_rsp_data, last_rsp[0]);
      check("d_rsp_data", d_rsp_data, last_rsp[1]);
      check("if_rsp_data", if_rsp_data, last_rsp[2]);

      if (e_tw || e_d || e_if) begin
        p_own   = e_tw ? 0 : e_d ? 1 : 2;
        p_addr  = e_tw ? tw_addr : e_d ? d_addr : if_addr;
        p_we    = e_d && d_we;
        p_size  = e_d ? d_size : 2'b10;
        p_wdata = d_wdata;
        p_err   = e_d && d_size == 2'b11;
        op_cyc  = cyc + 1; rsp_cyc = cyc + 3; free_at = cyc + 4;
        if (e_d)  m_if_turn = 1'b1;
        if (e_if) m_if_turn = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- directed helpers
  task automatic do_d(input bit we, input logic [1:0] size, input logic [13:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output bit err, output int lat, output int wen_cnt);
    bit got = 0;
    lat = -1; wen_cnt = 0; rdata = '0; err = 0;
    @(posedge clock); #1;
    d_valid = 1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (d_ready) got = 1;
    end
    if (!got) begin
      check("d_ready_timeout", 0, 1);
      d_valid = 0;
      return;
    end
    @(posedge clock); #1 d_valid = 0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clock);
      if (mem_wen) wen_cnt++;
      if (d_rsp_valid) begin lat = k; rdata = d_rsp_data; err = d_rsp_err; end
    end
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat, wc, n, ntw, g, tfirst, tifrsp, overlap;
  int          order [8];
  int          seq [6];
  bit          injected, got6;
  logic [63:0] seq_pk, exp_pk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1; tw_valid = 0; d_valid = 0; if_valid = 0;
    tw_addr = '0; d_addr = '0; if_addr = '0; d_we = 0; d_size = 2'b10; d_wdata = '0;
    #3 reset_n = 0;
    repeat (2) @(posedge clock);
    #1 d_valid = 1;
    #1 check("ready_in_reset", {tw_ready, d_ready, if_ready}, 0);
    d_valid = 0;
    @(posedge clock); #1 reset_n = 1;
    #1 check("rsp_data_after_reset", d_rsp_data, 0);

    // word write then read back
    do_d(1, 2'b10, 14'h10, 32'hDEADBEEF, rd, er, lat, wc);
    check("t1_wr_lat", lat, 3);
    check("t1_wr_wen_cycles", wc, 1);
    check("t1_wr_ack", {er, rd}, 0);
    do_d(0, 2'b10, 14'h10, 32'h0, rd, er, lat, wc);
    check("t1_rd_lat", lat, 3);
    check("t1_rd_data", rd, 32'hDEADBEEF);

    // sub-word reads
    do_d(1, 2'b10, 14'h20, 32'h12345678, rd, er, lat, wc);
    do_d(0, 2'b01, 14'h22, 32'h0, rd, er, lat, wc);
    check("t2_half", rd, 32'h00001234);
    do_d(0, 2'b00, 14'h21, 32'h0, rd, er, lat, wc);
    check("t2_byte", rd, 32'h00000056);

    // reserved size: error ack, memory untouched
    do_d(1, 2'b10, 14'h40, 32'hCAFEF00D, rd, er, lat, wc);
    do_d(1, 2'b11, 14'h40, 32'h11111111, rd, er, lat, wc);
    check("t5_err", {er, rd}, {1'b1, 32'h0});
    check("t5_lat_noen", {lat, wc}, {32'd3, 32'd0});
    do_d(0, 2'b10, 14'h40, 32'h0, rd, er, lat, wc);
    check("t5_mem_kept", rd, 32'hCAFEF00D);

    // tw + d + if together
    @(posedge clock); #1;
    tw_valid = 1; tw_addr = 14'h100; d_valid = 1; d_we = 0; d_size = 2'b10; d_addr = 14'h104;
    if_valid = 1; if_addr = 14'h108;
    n = 0; tfirst = -1; tifrsp = -1; overlap = 0;
    for (int t = 0; t < 40 && tifrsp < 0; t++) begin
      @(negedge clock);
      if (int'(tw_ready) + int'(d_ready) + int'(if_ready) > 1) overlap++;
      g = tw_ready ? 0 : d_ready ? 1 : if_ready ? 2 : -1;
      if (g >= 0 && n < 8) begin order[n] = g; n++; if (tfirst < 0) tfirst = t; end
      if (if_rsp_valid) tifrsp = t;
      @(posedge clock); #1;
      if (g == 0) tw_valid = 0;
      if (g == 1) d_valid = 0;
      if (g == 2) if_valid = 0;
    end
    check("t3_order", {n[7:0], 2'(order[0]), 2'(order[1]), 2'(order[2])}, {8'd3, 2'd0, 2'd1, 2'd2});
    check("t3_if_rsp_time", tifrsp - tfirst, 11);
    check("t3_overlap", overlap, 0);

    // d and if streaming, tw injected after the third grant
    d_valid = 1; d_we = 0; d_size = 2'b10; d_addr = 14'($urandom_range(0, 255));
    if_valid = 1; if_addr = 14'($urandom_range(0, 255));
    n = 0; ntw = 0; injected = 0;
    for (int t = 0; t < 80 && ntw < 6; t++) begin
      @(negedge clock);
      g = tw_ready ? 0 : d_ready ? 1 : if_ready ? 2 : -1;
      if (g >= 0 && n < 8) begin order[n] = g; n++; end
      if (g > 0) begin seq[ntw] = g; ntw++; end
      @(posedge clock); #1;
      if (g == 0) tw_valid = 0;
      if (g == 1) d_addr = 14'($urandom_range(0, 255));
      if (g == 2) if_addr = 14'($urandom_range(0, 255));
      if (ntw == 3 && !injected) begin
        tw_valid = 1; tw_addr = 14'($urandom_range(0, 255)); injected = 1;
      end
    end
    d_valid = 0; if_valid = 0;
    got6 = (ntw == 6);
    seq_pk = '0;
    for (int i = 0; i < 6; i++) seq_pk = {seq_pk[61:0], 2'(seq[i])};
`ifdef DRAM_ARB_RR_EN
    exp_pk = {52'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
`else
    exp_pk = {52'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
    check("t4_grant_seq", {got6, seq_pk[11:0]}, {1'b1, exp_pk[11:0]});
    check("t4_tw_preempt", order[3], 0);

    // reset during capture drops the access
    @(posedge clock); #1;
    d_valid = 1; d_we = 0; d_size = 2'b10; d_addr = 14'h20;
    g = 0;
    for (int i = 0; i < 20 && g == 0; i++) begin @(negedge clock); if (d_ready) g = 1; end
    check("t6_accept", g, 1);
    @(posedge clock); #1 d_valid = 0;
    @(posedge clock); #1 reset_n = 0;
    #1 check("t6_outputs_cleared", {tw_ready, d_ready, if_ready, tw_rsp_valid, d_rsp_valid,
                                    if_rsp_valid, d_rsp_err, mem_ren, mem_wen, d_rsp_data}, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (d_rsp_valid) n++;
      if (i == 2) begin @(posedge clock); #1 reset_n = 1; end
    end
    check("t6_no_rsp", n, 0);
    do_d(0, 2'b10, 14'h20, 32'h0, rd, er, lat, wc);
    check("t6_after_reset", {lat[7:0], rd}, {8'd3, 32'h12345678});

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bit at, ad, ai;
      @(negedge clock);
      at = tw_ready; ad = d_ready; ai = if_ready;
      @(posedge clock); #1;
      if (at || !tw_valid || $urandom_range(0, 7) == 0) begin
        tw_valid = ($urandom_range(0, 3) == 0); tw_addr = 14'($urandom_range(0, 255));
      end
      if (ad || !d_valid || $urandom_range(0, 7) == 0) begin
        d_valid = ($urandom_range(0, 1) == 0); d_addr = 14'($urandom_range(0, 255));
        d_we = 1'($urandom); d_wdata = $urandom;
        d_size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      if (ai || !if_valid || $urandom_range(0, 7) == 0) begin
        if_valid = ($urandom_range(0, 2) == 0); if_addr = 14'($urandom_range(0, 255));
      end
    end
    tw_valid = 0; d_valid = 0; if_valid = 0;
    repeat (10) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
